data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Load/store controller between the EX/MEM pipeline registers and the data SRAM-like port. It accepts one load or store per transaction and handles the addr_ok/data_ok handshake with variable latency. It generates byte strobes, replicates store data, sign/zero-extends load data and raises address-alignment exceptions. While a transaction is in flight it drives a stall request into the pipeline stall bus, so the MEM stage only sees completed results.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; byte lanes = 4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  EX issues memory op this cycle
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word; 3 reserved (treated as word)
req_sign  in  1  load sign-extend enable
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-aligned
req_ready  out  1  controller idle, can accept
stallreq  out  1  hold pipeline (stage index 3 request)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  formatted load data (0 for stores)
adel  out  1  load misaligned pulse
ades  out  1  store misaligned pulse
mem_req  out  1  memory request
mem_wr  out  1  write
mem_size  out  2  size code
mem_addr  out  ADDR_W  address
mem_wstrb  out  4  byte write strobes
mem_wdata  out  DATA_W  lane-replicated store data
mem_addr_ok  in  1  address accepted
mem_data_ok  in  1  data returned / write done
mem_rdata  in  DATA_W  raw read word

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- FSM states: IDLE, ADDR, DATA, RESP. Reset -> IDLE. On reset all outputs are 0 except req_ready=1.
- IDLE: req_ready=1.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]!=0): no transaction; adel or ades pulses in that same cycle; stay IDLE.
  - Aligned request: latch we/size/sign/addr/wdata; -> ADDR next cycle.
- ADDR: mem_req=1, with all mem_* outputs driven from the latches. The request is held stable until mem_addr_ok=1, then -> DATA.
- DATA: mem_req=0. Wait for mem_data_ok.
  - On mem_data_ok, register the formatted rdata (0 for stores) into resp_rdata; -> RESP.
  - mem_data_ok seen in ADDR, or in the same cycle as addr_ok, is ignored. Earliest completion is the cycle after addr_ok.
- RESP: resp_valid=1 for exactly one cycle; -> IDLE. resp_rdata holds its value until the next RESP.
- stallreq = (IDLE & req_valid & aligned) | ADDR | DATA. It is low in RESP and low on misaligned requests.
- Minimum latency: request at cycle T -> resp_valid at T+3 (addr_ok at T+1, data_ok at T+2).
- Store strobes:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data: mem_wdata = byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata. Loads drive mem_wstrb=0.
- Load formatting: select lane by latched addr[1:0]. byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]. Extend with the sign bit if req_sign, else zero.
- req_valid outside IDLE is ignored; EX holds the request because stallreq is high.
- Reset in any state -> IDLE next edge; mem_req drops immediately. Stray data_ok in IDLE or RESP is ignored.

Decomposition:
- Shared package/defines: size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) and FSM state encoding.
- One combinational sub-module, data_align: inputs size, sign, offset, raw word; outputs formatted load data, wstrb and replicated wdata. Both the FSM and the testbench reference model reuse it.

Test Plan:
- lw 0x00001000, addr_ok same cycle as mem_req, data_ok 2 cycles later, rdata 0x12345678 -> resp_rdata 0x12345678, resp_valid at T+4, stallreq high T..T+3.
- lb sign=1 addr 0x1003, rdata 0x80AABBCC -> resp_rdata 0xFFFFFF80. Repeat with sign=0 (lbu) -> 0x00000080.
- lhu addr 0x2002, rdata 0xBEEF1234 -> 0x0000BEEF. lh of the same -> 0xFFFFBEEF.
- sb addr 0x3001 wdata 0x000000AB -> mem_wstrb 4'b0010, mem_wdata 0xABABABAB. sh addr 0x3002 -> strobe 4'b1100, resp_rdata 0.
- lw addr 0x4002 -> adel pulse, no mem_req, stallreq 0, FSM stays IDLE. sh addr 0x4001 -> ades pulse.
- addr_ok delayed 3 cycles with mem_* held stable, then rst asserted in DATA -> IDLE next edge; a later data_ok produces no resp_valid.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory load/store controller:
// access size codes, FSM state encoding and the alignment rule.
package data_mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Size code 3 is reserved and behaves like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        if (size == SZ_BYTE)
            return 1'b0;
        else if (size == SZ_HALF)
            return offset[0];
        else
            return |offset;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_align.sv
// Byte-lane formatting for loads (lane select + sign/zero extend) and
// stores (write strobes + lane replication of the store data).
module data_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
        o_rdata = i_rdata;
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
                o_wstrb = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_rdata = {{16{i_sign & w_half[15]}}, w_half};
                o_wstrb = 4'b0011 << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between EX/MEM and the data SRAM-like port:
// one transaction at a time over the addr_ok/data_ok handshake.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stallreq,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              adel,
    output logic              ades,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_misaligned;
    logic              w_accept;
    logic              w_in_addr;
    logic [DATA_W-1:0] w_load_fmt;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata_rep;

    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign w_accept     = (r_state == ST_IDLE) && req_valid && !w_misaligned;
    assign w_in_addr    = (r_state == ST_ADDR) && !rst;

    data_align u_align (
        .i_size   (r_size),
        .i_sign   (r_sign),
        .i_offset (r_addr[1:0]),
        .i_rdata  (mem_rdata),
        .i_wdata  (r_wdata),
        .o_rdata  (w_load_fmt),
        .o_wstrb  (w_wstrb),
        .o_wdata  (w_wdata_rep)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_sign  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= (req_size == 2'd3) ? SZ_WORD : req_size;
                r_sign  <= req_sign;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == ST_DATA && mem_data_ok)
                r_rdata <= r_we ? '0 : w_load_fmt;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        stallreq   = 1'b0;
        resp_valid = 1'b0;
        adel       = 1'b0;
        ades       = 1'b0;
        mem_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_misaligned) begin
                        adel = !req_we;
                        ades = req_we;
                    end else begin
                        stallreq = 1'b1;
                        w_next   = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                mem_req  = 1'b1;
                stallreq = 1'b1;
                if (mem_addr_ok)
                    w_next = ST_DATA;
            end
            ST_DATA: begin
                stallreq = 1'b1;
                if (mem_data_ok)
                    w_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // Reset silences the pipeline-facing requests in the same cycle.
        if (rst) begin
            stallreq = 1'b0;
            adel     = 1'b0;
            ades     = 1'b0;
            mem_req  = 1'b0;
        end
    end

    assign resp_rdata = r_rdata;
    assign mem_wr     = w_in_addr && r_we;
    assign mem_size   = w_in_addr ? r_size : 2'd0;
    assign mem_addr   = w_in_addr ? r_addr : '0;
    assign mem_wstrb  = (w_in_addr && r_we) ? w_wstrb : 4'b0000;
    assign mem_wdata  = (w_in_addr && r_we) ? w_wdata_rep : '0;

endmodule
